// File: rtl/spi_pkg.sv
// Shared types and elaboration helpers for the configurable SPI master.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } spi_state_t;

    // System clocks per SCLK half-period.
    function automatic int calc_half_div(input int ref_clk, input int sclk_hz);
        return ref_clk / (2 * sclk_hz);
    endfunction

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period counter: runs while enabled, ticks on the terminal count,
// and flags the cycle before the tick so callers can pre-register outputs.
module spi_clk_div
    import spi_pkg::*;
#(
    parameter int HALF_DIV = 2
)(
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick,
    output logic pre_tick
);

    localparam int CNT_W = cnt_width(HALF_DIV);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HALF_DIV - 1);
    localparam logic [CNT_W-1:0] PRE_CNT  = CNT_W'(HALF_DIV - 2);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (!en || cnt_reg == LAST_CNT) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign tick     = en && (cnt_reg == LAST_CNT);
    assign pre_tick = en && (cnt_reg == PRE_CNT);

endmodule

// File: rtl/spi_master_txrx_cfg.sv
// Configurable SPI master (any CPOL/CPHA, width, bit order, bursts under one CS).
// Define SPI_MISO_EN to build the MISO receive path; otherwise rx outputs are 0.
module spi_master_txrx_cfg
    import spi_pkg::*;
#(
    parameter int REF_CLK   = 50_000_000,
    parameter int SPI_SCLK  = 50_000,
    parameter int DATA_W    = 8,
    parameter bit CPOL      = 1'b1,
    parameter bit CPHA      = 1'b0,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CS_GAP    = 2
)(
    input  logic              In_clk,
    input  logic              In_rst,
    input  logic              In_tx_valid,
    input  logic [DATA_W-1:0] In_tx_data,
    input  logic              In_tx_last,
    output logic              Out_tx_ready,
    output logic              Out_busy,
    output logic              Out_rx_valid,
    output logic [DATA_W-1:0] Out_rx_data,
    input  logic              In_spi_miso,
    output logic              Out_spi_cs_n,
    output logic              Out_spi_sclk,
    output logic              Out_spi_mosi
);

    localparam int HALF_DIV = calc_half_div(REF_CLK, SPI_SCLK);
    localparam int EDGES    = 2 * DATA_W;
    localparam int ECNT_W   = cnt_width((EDGES > CS_GAP) ? EDGES : CS_GAP);
    localparam logic [ECNT_W-1:0] LAST_EDGE = ECNT_W'(EDGES - 1);
    localparam logic [ECNT_W-1:0] LAST_GAP  = ECNT_W'(CS_GAP - 1);

    generate
        if (HALF_DIV < 2) begin : g_bad_div
            $error("HALF_DIV = REF_CLK/(2*SPI_SCLK) must be at least 2");
        end
        if (DATA_W < 4 || DATA_W > 32) begin : g_bad_width
            $error("DATA_W must be in 4..32");
        end
        if (CS_GAP < 1) begin : g_bad_gap
            $error("CS_GAP must be at least 1");
        end
    endgenerate

    function automatic logic head_bit(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? w[DATA_W-1] : w[0];
    endfunction

    function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
    endfunction

    spi_state_t        state_reg, state_next;
    logic [ECNT_W-1:0] edge_cnt_reg, edge_cnt_next;
    logic [DATA_W-1:0] tx_shift_reg, tx_shift_next;
    logic              last_reg, last_next;
    logic              hold_wait_reg, hold_wait_next;
    logic              ready_reg, ready_next;
    logic              busy_reg, busy_next;
    logic              cs_n_reg, cs_n_next;
    logic              sclk_reg, sclk_next;
    logic              mosi_reg, mosi_next;

    logic              div_en, tick, pre_tick;
    logic              accept, leading, final_edge;
    logic              sample_en, shift_done;
    logic [DATA_W-1:0] load_shift;
    logic              load_mosi;

    // The divider is frozen while parked in HOLD so a late word restarts it from zero.
    assign div_en = (state_reg != IDLE) && !hold_wait_reg;

    spi_clk_div #(
        .HALF_DIV (HALF_DIV)
    ) u_clk_div (
        .clk      (In_clk),
        .rst      (In_rst),
        .en       (div_en),
        .tick     (tick),
        .pre_tick (pre_tick)
    );

    assign accept     = In_tx_valid && ready_reg;
    assign leading    = !edge_cnt_reg[0];
    assign final_edge = (edge_cnt_reg == LAST_EDGE);
    // CPHA=0 presents bit 0 at load time; CPHA=1 presents it on the first leading edge.
    assign load_shift = CPHA ? In_tx_data : advance(In_tx_data);
    assign load_mosi  = CPHA ? mosi_reg : head_bit(In_tx_data);

    always_ff @(posedge In_clk or posedge In_rst) begin
        if (In_rst) begin
            state_reg     <= IDLE;
            edge_cnt_reg  <= '0;
            tx_shift_reg  <= '0;
            last_reg      <= 1'b0;
            hold_wait_reg <= 1'b0;
            ready_reg     <= 1'b0;
            busy_reg      <= 1'b0;
            cs_n_reg      <= 1'b1;
            sclk_reg      <= CPOL;
            mosi_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            edge_cnt_reg  <= edge_cnt_next;
            tx_shift_reg  <= tx_shift_next;
            last_reg      <= last_next;
            hold_wait_reg <= hold_wait_next;
            ready_reg     <= ready_next;
            busy_reg      <= busy_next;
            cs_n_reg      <= cs_n_next;
            sclk_reg      <= sclk_next;
            mosi_reg      <= mosi_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        edge_cnt_next  = edge_cnt_reg;
        tx_shift_next  = tx_shift_reg;
        last_next      = last_reg;
        hold_wait_next = hold_wait_reg;
        ready_next     = ready_reg;
        busy_next      = busy_reg;
        cs_n_next      = cs_n_reg;
        sclk_next      = sclk_reg;
        mosi_next      = mosi_reg;
        sample_en      = 1'b0;
        shift_done     = 1'b0;

        case (state_reg)
            IDLE: begin
                ready_next = 1'b1;
                if (accept) begin
                    ready_next    = 1'b0;
                    busy_next     = 1'b1;
                    cs_n_next     = 1'b0;
                    last_next     = In_tx_last;
                    tx_shift_next = load_shift;
                    mosi_next     = load_mosi;
                    state_next    = SETUP;
                end
            end

            SETUP: begin
                if (tick) begin
                    edge_cnt_next = '0;
                    state_next    = SHIFT;
                end
            end

            SHIFT: begin
                if (tick) begin
                    sclk_next     = !sclk_reg;
                    edge_cnt_next = edge_cnt_reg + 1'b1;
                    if (leading == CPHA) begin
                        // drive edge; with CPHA=0 the final trailing edge drives nothing
                        if (CPHA || !final_edge) begin
                            mosi_next     = head_bit(tx_shift_reg);
                            tx_shift_next = advance(tx_shift_reg);
                        end
                    end else begin
                        sample_en = 1'b1;
                    end
                    if (final_edge) begin
                        sclk_next     = CPOL;
                        edge_cnt_next = '0;
                        shift_done    = 1'b1;
                        state_next    = HOLD;
                    end
                end
            end

            HOLD: begin
                if (pre_tick && !last_reg) begin
                    ready_next = 1'b1;
                end
                if (accept) begin
                    ready_next     = 1'b0;
                    hold_wait_next = 1'b0;
                    last_next      = In_tx_last;
                    tx_shift_next  = load_shift;
                    mosi_next      = load_mosi;
                    edge_cnt_next  = '0;
                    state_next     = CPHA ? SETUP : SHIFT;
                end else if (tick) begin
                    if (last_reg) begin
                        cs_n_next     = 1'b1;
                        ready_next    = 1'b0;
                        edge_cnt_next = '0;
                        state_next    = GAP;
                    end else begin
                        hold_wait_next = 1'b1;
                    end
                end
            end

            GAP: begin
                if (tick) begin
                    if (edge_cnt_reg == LAST_GAP) begin
                        busy_next  = 1'b0;
                        ready_next = 1'b1;
                        state_next = IDLE;
                    end else begin
                        edge_cnt_next = edge_cnt_reg + 1'b1;
                    end
                end
            end

            default: state_next = IDLE;
        endcase
    end

    assign Out_tx_ready = ready_reg;
    assign Out_busy     = busy_reg;
    assign Out_spi_cs_n = cs_n_reg;
    assign Out_spi_sclk = sclk_reg;
    assign Out_spi_mosi = mosi_reg;

`ifdef SPI_MISO_EN
    logic [DATA_W-1:0] rx_shift_reg, rx_shift_next;
    logic [DATA_W-1:0] rx_data_reg;
    logic              rx_valid_reg;

    always_comb begin
        rx_shift_next = rx_shift_reg;
        if (sample_en) begin
            rx_shift_next = MSB_FIRST ? {rx_shift_reg[DATA_W-2:0], In_spi_miso}
                                      : {In_spi_miso, rx_shift_reg[DATA_W-1:1]};
        end
    end

    // rx_shift_next already holds the CPHA=1 final sample taken on the last edge.
    always_ff @(posedge In_clk or posedge In_rst) begin
        if (In_rst) begin
            rx_shift_reg <= '0;
            rx_data_reg  <= '0;
            rx_valid_reg <= 1'b0;
        end else begin
            rx_shift_reg <= rx_shift_next;
            rx_valid_reg <= shift_done;
            if (shift_done) begin
                rx_data_reg <= rx_shift_next;
            end
        end
    end

    assign Out_rx_valid = rx_valid_reg;
    assign Out_rx_data  = rx_data_reg;
`else
    logic unused_rx;
    assign unused_rx    = In_spi_miso ^ sample_en ^ shift_done;
    assign Out_rx_valid = 1'b0;
    assign Out_rx_data  = '0;
`endif

endmodule

// File: tb/tb_spi_master_txrx_cfg.sv
// Four DUTs (SPI modes 0..3) driven by random word streams; an SPI slave model
// per DUT reassembles MOSI words and checks them against a scoreboard queue.
module tb_spi_master_txrx_cfg;

    localparam int DW   = 8;
    localparam int HD   = 5;
    localparam int GAPN = 2;

    int   vectors     = 0;
    int   miscompares = 0;
    logic clk = 1'b0;

    always #10 clk = ~clk;

    task automatic chk(input string what, input int mode, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL mode%0d %s: got %0h, expected %0h", mode, what, act, exp);
        end
    endtask

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_mode
            localparam bit P_CPOL = (gi >= 2);
            localparam bit P_CPHA = (gi % 2 == 1);
            localparam bit P_MSB  = (gi != 1);

            logic          rst = 1'b1;
            logic          tx_valid = 1'b0;
            logic          tx_last = 1'b0;
            logic [DW-1:0] tx_data = '0;
            logic          tx_ready, busy, rx_valid, cs_n, sclk, mosi;
            logic [DW-1:0] rx_data;
            logic [DW-1:0] exp_q[$];
            logic [DW-1:0] exp_rx_q[$];
            bit            fin = 1'b0;

            spi_master_txrx_cfg #(
                .REF_CLK   (50_000_000),
                .SPI_SCLK  (5_000_000),
                .DATA_W    (DW),
                .CPOL      (P_CPOL),
                .CPHA      (P_CPHA),
                .MSB_FIRST (P_MSB),
                .CS_GAP    (GAPN)
            ) dut (
                .In_clk       (clk),
                .In_rst       (rst),
                .In_tx_valid  (tx_valid),
                .In_tx_data   (tx_data),
                .In_tx_last   (tx_last),
                .Out_tx_ready (tx_ready),
                .Out_busy     (busy),
                .Out_rx_valid (rx_valid),
                .Out_rx_data  (rx_data),
                .In_spi_miso  (mosi),
                .Out_spi_cs_n (cs_n),
                .Out_spi_sclk (sclk),
                .Out_spi_mosi (mosi)
            );

            // ---------------- slave model / monitor ----------------
            int            cyc = 0, last_edge_cyc = 0, edge_idx = 0, nbits = 0, rise_cyc = 0;
            int            falls = 0, rises = 0;
            bit            have_rise = 1'b0;
            logic          sclk_p = P_CPOL, cs_p = 1'b1, mosi_p = 1'b0;
            logic [DW-1:0] word = '0, e = '0;

            always @(negedge clk) begin
                cyc++;
                if (rst) begin
                    nbits     = 0;
                    edge_idx  = 0;
                    have_rise = 1'b0;
                end else begin
                    if (cs_p && !cs_n) begin
                        falls++;
                        chk("sclk idle at cs fall", gi, sclk, P_CPOL);
                        if (have_rise) chk("cs high time >= gap", gi, (cyc - rise_cyc) >= GAPN * HD, 1);
                        edge_idx = 0;
                        nbits    = 0;
                    end
                    if (!cs_p && cs_n) begin
                        rises++;
                        chk("whole words under cs", gi, edge_idx % (2 * DW), 0);
                        chk("sclk idle at cs rise", gi, sclk, P_CPOL);
                        rise_cyc  = cyc;
                        have_rise = 1'b1;
                    end
                    if (cs_n) chk("sclk quiet while cs high", gi, sclk, sclk_p);
                    if (!cs_n && sclk != sclk_p) begin
                        if (edge_idx % (2 * DW) != 0) chk("sclk half period", gi, cyc - last_edge_cyc, HD);
                        last_edge_cyc = cyc;
                        edge_idx++;
                        if ((sclk_p == P_CPOL) != P_CPHA) begin
                            chk("mosi stable at sample edge", gi, mosi, mosi_p);
                            word[P_MSB ? DW - 1 - nbits : nbits] = mosi;
                            nbits++;
                            if (nbits == DW) begin
                                nbits = 0;
                                chk("word was expected", gi, exp_q.size() != 0, 1);
                                if (exp_q.size() != 0) begin
                                    e = exp_q.pop_front();
                                    chk("mosi word", gi, word, e);
                                    $display("mode%0d word out %02h (expected %02h)", gi, word, e);
                                end
                            end
                        end
                    end
`ifdef SPI_MISO_EN
                    if (rx_valid) begin
                        chk("rx_valid was expected", gi, exp_rx_q.size() != 0, 1);
                        if (exp_rx_q.size() != 0) begin
                            e = exp_rx_q.pop_front();
                            chk("rx word", gi, rx_data, e);
                            $display("mode%0d word in  %02h (expected %02h)", gi, rx_data, e);
                        end
                    end
`endif
                end
                sclk_p = sclk;
                cs_p   = cs_n;
                mosi_p = mosi;
            end

            // ---------------- stimulus ----------------
            task automatic send(input logic [DW-1:0] d, input logic l, input bit expect_it,
                                input int pre_delay, input bit mid_burst);
                int n;
                if (mid_burst) begin
                    n = 0;
                    while (!tx_ready && n < 400) begin
                        @(negedge clk);
                        n++;
                    end
                    chk("ready rises in hold", gi, tx_ready, 1);
                end
                repeat (pre_delay) begin
                    @(negedge clk);
                    if (mid_burst) begin
                        chk("hold keeps cs low", gi, cs_n, 0);
                        chk("hold keeps sclk idle", gi, sclk, P_CPOL);
                        chk("hold keeps ready", gi, tx_ready, 1);
                    end
                end
                tx_data  = d;
                tx_last  = l;
                tx_valid = 1'b1;
                n = 0;
                while (!tx_ready && n < 2000) begin
                    @(negedge clk);
                    n++;
                end
                chk("accepted within budget", gi, tx_ready, 1);
                if (tx_ready) begin
                    @(posedge clk);
                    if (expect_it) begin
                        exp_q.push_back(d);
                        exp_rx_q.push_back(d);
                    end
                    @(negedge clk);
                    chk("cs low after accept", gi, cs_n, 0);
                    chk("busy after accept", gi, busy, 1);
                    chk("ready cleared after accept", gi, tx_ready, 0);
                end
                tx_valid = 1'b0;
                tx_data  = DW'($urandom);
            endtask

            task automatic wait_idle();
                int n;
                n = 0;
                while (busy && n < 1000) begin
                    @(negedge clk);
                    n++;
                end
                chk("busy falls", gi, busy, 0);
            endtask

            initial begin
                logic [DW-1:0] d;
                logic          l;
                bit            in_burst;
                int            f0, r0;

                repeat (3) @(negedge clk);
                chk("reset cs_n", gi, cs_n, 1);
                chk("reset sclk", gi, sclk, P_CPOL);
                chk("reset mosi", gi, mosi, 0);
                chk("reset ready", gi, tx_ready, 0);
                chk("reset busy", gi, busy, 0);
                chk("reset rx_valid", gi, rx_valid, 0);
                chk("reset rx_data", gi, rx_data, 0);
                #2 rst = 1'b0;
                @(negedge clk);
                @(negedge clk);
                chk("ready after reset", gi, tx_ready, 1);

                // directed words from the plan, one per mode
                f0 = falls;
                r0 = rises;
                case (gi)
                    0: begin
                        send(8'h12, 1'b0, 1'b1, 0, 1'b0);
                        send(8'h34, 1'b1, 1'b1, 20, 1'b1);
                    end
                    1: send(8'h3C, 1'b1, 1'b1, 0, 1'b0);
                    2: send(8'hA5, 1'b1, 1'b1, 0, 1'b0);
                    default: send(8'hC3, 1'b1, 1'b1, 0, 1'b0);
                endcase
                wait_idle();
                chk("one cs fall per burst", gi, falls - f0, 1);
                chk("one cs rise per burst", gi, rises - r0, 1);

                in_burst = 1'b0;
                for (int i = 0; i < 14; i++) begin
                    d = DW'($urandom);
                    l = (i == 13) ? 1'b1 : ($urandom_range(0, 2) == 0);
                    send(d, l, 1'b1, in_burst ? $urandom_range(0, 6) : $urandom_range(0, 3), in_burst);
                    in_burst = !l;
                end
                wait_idle();

                // abort during the 4th bit, then recover with 8'hFF
                send(8'h96, 1'b1, 1'b0, 0, 1'b0);
                repeat (36) @(negedge clk);
                #3 rst = 1'b1;
                #1;
                chk("abort cs_n high at once", gi, cs_n, 1);
                chk("abort sclk idle", gi, sclk, P_CPOL);
                chk("abort busy low", gi, busy, 0);
                @(negedge clk);
                @(negedge clk);
                #2 rst = 1'b0;
                @(negedge clk);
                @(negedge clk);
                chk("ready after abort", gi, tx_ready, 1);
                chk("cs high after abort", gi, cs_n, 1);
                send(8'hFF, 1'b1, 1'b1, 0, 1'b0);
                wait_idle();
                repeat (3) @(negedge clk);
                chk("tx words outstanding", gi, exp_q.size(), 0);
`ifdef SPI_MISO_EN
                chk("rx words outstanding", gi, exp_rx_q.size(), 0);
`endif
                fin = 1'b1;
            end
        end
    endgenerate

    initial begin
        int n;
        n = 0;
        while (!(g_mode[0].fin && g_mode[1].fin && g_mode[2].fin && g_mode[3].fin) && n < 60000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60000) begin
            vectors++;
            miscompares++;
            $display("FAIL watchdog: done flags %b%b%b%b, expected 1111",
                     g_mode[3].fin, g_mode[2].fin, g_mode[1].fin, g_mode[0].fin);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
